// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// WB_DATA_W is the default register width; wb_entry_t is the default-width
// entry (destination register plus data).
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

    typedef enum logic {
        ALU_PRI = 1'b0,
        LD_PRI  = 1'b1
    } arb_state_t;

    // x0 is hardwired to zero; anything aimed at it is consumed without a write.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
        return (rd == '0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: load-response buffer for the write-back arbiter.
// DEPTH must be a power of two (pointers wrap by natural overflow).
// Push into a full FIFO and pop from an empty FIFO are ignored.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: writer side of the 32x32 register file write port.
// Merges single-cycle ALU results and buffered load responses into one
// registered write stream, and tracks outstanding loads in a scoreboard.
// Optional feature macro: REGFILE_WB_BYPASS_EN adds rs1/rs2 forwarding hits
// against the registered write port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ALU_PRI | ALU result wins if valid; otherwise FIFO head pops if present
// LD_PRI  | ALU starved the FIFO too long; ALU stalled, head pops once
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int WORD_LENGTH  = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_ADDR_W-1:0]  alu_rd,
    input  logic [WORD_LENGTH-1:0] alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [REG_ADDR_W-1:0]  ld_rd,
    input  logic [WORD_LENGTH-1:0] ld_data,
    input  logic                   iss_valid,
    input  logic [REG_ADDR_W-1:0]  iss_rd,
    output logic [REG_COUNT-1:0]   busy,
    output logic                   wr_en,
    output logic [REG_ADDR_W-1:0]  wr_add,
    output logic [WORD_LENGTH-1:0] wr_data
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0]  rs1_add,
    input  logic [REG_ADDR_W-1:0]  rs2_add,
    output logic                   fwd1_hit,
    output logic                   fwd2_hit
`endif
);

    localparam int ENTRY_W = REG_ADDR_W + WORD_LENGTH;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W    = $clog2(STARVE_LIMIT + 1);

    // Entry layout follows WORD_LENGTH rather than the package default width.
    typedef struct packed {
        logic [REG_ADDR_W-1:0]  rd;
        logic [WORD_LENGTH-1:0] data;
    } entry_t;

    entry_t           ld_entry;
    entry_t           head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             alu_win;
    logic [SC_W-1:0]  starve_cnt;
    logic             starve_hit;

    logic [REG_COUNT-1:0] busy_d;

    // ld_ready depends only on registered occupancy, never on a same-cycle pop.
    assign ld_ready  = !fifo_full;
    assign fifo_push = ld_valid && ld_ready && !is_x0(ld_rd);
    assign ld_entry  = {ld_rd, ld_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ld_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign starve_hit = (starve_cnt == SC_W'(STARVE_LIMIT - 1));

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ALU_PRI;
        else      state_q <= state_d;
    end

    // Winner selection and next state; exactly one winner per cycle at most.
    always_comb begin
        state_d   = state_q;
        alu_ready = 1'b0;
        alu_win   = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            ALU_PRI: begin
                alu_ready = 1'b1;
                if (alu_valid) begin
                    alu_win = 1'b1;
                    if (!fifo_empty && starve_hit) state_d = LD_PRI;
                end else begin
                    fifo_pop = !fifo_empty;
                end
            end
            LD_PRI: begin
                // Head is always present here; leave after one pop regardless.
                fifo_pop = !fifo_empty;
                state_d  = ALU_PRI;
            end
            default: state_d = ALU_PRI;
        endcase
    end

    // Counts ALU wins that bypassed a waiting load; any pop or an empty FIFO clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (fifo_pop || (fifo_count == '0)) begin
            starve_cnt <= '0;
        end else if (alu_win) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered write port; x0 winners complete their handshake but never write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_add  <= '0;
            wr_data <= '0;
        end else if (alu_win) begin
            wr_en <= !is_x0(alu_rd);
            if (!is_x0(alu_rd)) begin
                wr_add  <= alu_rd;
                wr_data <= alu_data;
            end
        end else if (fifo_pop) begin
            wr_en <= !is_x0(head.rd);
            if (!is_x0(head.rd)) begin
                wr_add  <= head.rd;
                wr_data <= head.data;
            end
        end else begin
            wr_en <= 1'b0;
        end
    end

    // Scoreboard update: pop clears, issue sets (set applied last so it wins), x0 never busy.
    always_comb begin
        busy_d = busy;
        if (fifo_pop)  busy_d[head.rd] = 1'b0;
        if (iss_valid) busy_d[iss_rd]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_d;
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the in-flight write to readers of the same register this cycle.
    assign fwd1_hit = wr_en && !is_x0(wr_add) && (wr_add == rs1_add);
    assign fwd2_hit = wr_en && !is_x0(wr_add) && (wr_add == rs2_add);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, ALU path, load path,
// FIFO full / starvation, x0 handling and scoreboard set/clear collision.
// Bypass checks are compiled in when REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic        wr_en;
    logic [4:0]  wr_add;
    logic [31:0] wr_data;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]  rs1_add;
    logic [4:0]  rs2_add;
    logic        fwd1_hit;
    logic        fwd2_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .WORD_LENGTH  (32),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_add    (wr_add),
        .wr_data   (wr_data)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .rs1_add   (rs1_add),
        .rs2_add   (rs2_add),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h0000_0002;
        ld_valid = 1'b1;  ld_rd = 5'd4;  ld_data = 32'hAAAA_0004;
        iss_valid = 1'b1; iss_rd = 5'd6;
        repeat (3) tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 00000000", busy); end
        n_checks++; if (wr_add !== 5'd0) begin n_fail++; $display("FAIL reset_wr_add: got %0d want 0", wr_add); end
        n_checks++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
        tick(); tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_no_push: wr_en got %b want 0", wr_en); end
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy_after: got %h want 0", busy); end
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL alu_wr_en: got %b want 1", wr_en); end
        n_checks++; if (wr_add !== 5'd5) begin n_fail++; $display("FAIL alu_wr_add: got %0d want 5", wr_add); end
        n_checks++; if (wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alu_wr_data: got %h want deadbeef", wr_data); end
        tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL alu_idle_wr_en: got %b want 0", wr_en); end
        n_checks++; if (wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alu_hold_data: got %h want deadbeef", wr_data); end
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0011;
        tick();
        alu_rd = 5'd2; alu_data = 32'h0000_0022;
        n_checks++; if (wr_add !== 5'd1 || wr_data !== 32'h11) begin n_fail++; $display("FAIL b2b_first: got %0d/%h want 1/00000011", wr_add, wr_data); end
        tick();
        alu_valid = 1'b0;
        n_checks++; if (wr_en !== 1'b1 || wr_add !== 5'd2 || wr_data !== 32'h22) begin n_fail++; $display("FAIL b2b_second: got en=%b %0d/%h want 1 2/00000022", wr_en, wr_add, wr_data); end
        tick();
    endtask

    task automatic test_load_path();
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        n_checks++; if (busy !== 32'h0000_0080) begin n_fail++; $display("FAIL ld_busy_set: got %h want 00000080", busy); end
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_1234;
        #1;
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready: got %b want 1", ld_ready); end
        tick();
        ld_valid = 1'b0;
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL ld_accept_plus1: wr_en got %b want 0", wr_en); end
        n_checks++; if (busy !== 32'h0000_0080) begin n_fail++; $display("FAIL ld_busy_hold: got %h want 00000080", busy); end
        tick();
        n_checks++; if (wr_en !== 1'b1 || wr_add !== 5'd7 || wr_data !== 32'h1234) begin n_fail++; $display("FAIL ld_write: got en=%b %0d/%h want 1 7/00001234", wr_en, wr_add, wr_data); end
        n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL ld_busy_clear: got %h want 0", busy); end
        tick();
    endtask

    task automatic test_fifo_full_starve();
        for (int c = 0; c <= 14; c++) begin
            alu_valid = (c <= 9);
            alu_rd    = 5'd10;
            alu_data  = 32'(c);
            ld_valid  = (c <= 3);
            ld_rd     = 5'(11 + c);
            ld_data   = 32'h1000 + 32'(11 + c);
            #1;
            if (c == 3) begin
                n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL full_c3_ld_ready: got %b want 1", ld_ready); end
            end
            if (c == 4) begin
                n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_ld_ready: got %b want 0", ld_ready); end
            end
            if (c == 8) begin
                n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL starve_c8_alu_ready: got %b want 1", alu_ready); end
            end
            if (c == 9) begin
                n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL starve_alu_ready: got %b want 0", alu_ready); end
                n_checks++; if (wr_add !== 5'd10 || wr_data !== 32'd8) begin n_fail++; $display("FAIL starve_c9_write: got %0d/%h want 10/00000008", wr_add, wr_data); end
            end
            if (c == 10) begin
                n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL starve_release: alu_ready got %b want 1", alu_ready); end
                n_checks++; if (wr_en !== 1'b1 || wr_add !== 5'd11 || wr_data !== 32'h100B) begin n_fail++; $display("FAIL starve_drain: got en=%b %0d/%h want 1 11/0000100b", wr_en, wr_add, wr_data); end
            end
            if (c >= 11 && c <= 13) begin
                n_checks++; if (wr_en !== 1'b1 || wr_add !== 5'(c + 1) || wr_data !== 32'h1000 + 32'(c + 1)) begin n_fail++; $display("FAIL drain_order c=%0d: got en=%b %0d/%h want 1 %0d", c, wr_en, wr_add, wr_data, c + 1); end
            end
            if (c == 14) begin
                n_checks++; if (wr_en !== 1'b0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL drain_done: got en=%b ld_ready=%b want 0 1", wr_en, ld_ready); end
            end
            tick();
        end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic test_x0_collision();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_alu_ready: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_wr_en: got %b want 0", wr_en); end
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_valid = 1'b0;
        n_checks++; if (busy !== 32'h0000_0008) begin n_fail++; $display("FAIL coll_busy_set: got %h want 00000008", busy); end
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h0000_0033;
        tick();
        ld_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_valid = 1'b0;
        n_checks++; if (busy !== 32'h0000_0008) begin n_fail++; $display("FAIL coll_set_wins: got %h want 00000008", busy); end
        n_checks++; if (wr_en !== 1'b1 || wr_add !== 5'd3 || wr_data !== 32'h33) begin n_fail++; $display("FAIL coll_write: got en=%b %0d/%h want 1 3/00000033", wr_en, wr_add, wr_data); end
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0000_00EE;
        tick();
        ld_valid = 1'b0;
        tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_ld_not_pushed: wr_en got %b want 0", wr_en); end
    endtask

`ifdef REGFILE_WB_BYPASS_EN
    task automatic test_bypass();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0999;
        tick();
        alu_valid = 1'b0;
        rs1_add = 5'd9; rs2_add = 5'd0;
        #1;
        n_checks++; if (fwd1_hit !== 1'b1) begin n_fail++; $display("FAIL fwd1_hit: got %b want 1", fwd1_hit); end
        n_checks++; if (fwd2_hit !== 1'b0) begin n_fail++; $display("FAIL fwd2_hit: got %b want 0", fwd2_hit); end
        tick();
        n_checks++; if (fwd1_hit !== 1'b0) begin n_fail++; $display("FAIL fwd1_idle: got %b want 0", fwd1_hit); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
`ifdef REGFILE_WB_BYPASS_EN
        rs1_add = '0; rs2_add = '0;
`endif
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_load_path();
        test_fifo_full_starve();
        test_x0_collision();
`ifdef REGFILE_WB_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
